// File: rtl/seg_click_tracker.sv
// Turns cursor position and mouse button levels into the 7-bit lit-segment vector
// for the OLED seven-segment renderer, with click toggling, right-click clear and hold-off.
module seg_click_tracker #(
  parameter int unsigned HOLDOFF_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_x_cursor,
  input  logic [6:0] i_y_cursor,
  input  logic       i_left_click,
  input  logic       i_right_click,
  input  logic       i_clear,
  output logic [6:0] o_mouse_click,
  output logic [2:0] o_hover_seg,
  output logic       o_toggle_strobe,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HOLDOFF
  } state_t;

  localparam int unsigned CNT_W  = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int unsigned LOAD_I = (HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);
  localparam logic [2:0] NO_SEG = 3'd7;

  state_t           r_state;
  logic [CNT_W-1:0] r_holdCnt;
  logic [2:0]       r_selSeg;
  logic [2:0]       r_hoverSeg;
  logic [6:0]       r_mouseClick;
  logic             r_toggleStrobe;
  logic             r_leftQ;
  logic             r_rightQ;

  logic [2:0] w_hitSeg;
  logic       w_press;
  logic       w_release;
  logic       w_rclick;
  logic       w_onSel;
  logic [6:0] w_toggleMask;

  function automatic logic inBox(
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [7:0] x0,
    input logic [7:0] x1,
    input logic [6:0] y0,
    input logic [6:0] y1
  );
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  // Checked in index order so overlapping corners resolve to the lowest segment.
  function automatic logic [2:0] hitSeg(input logic [7:0] x, input logic [6:0] y);
    logic [2:0] seg;
    seg = NO_SEG;
    if      (inBox(x, y, 8'd9,  8'd29, 7'd4,  7'd6))  seg = 3'd0;
    else if (inBox(x, y, 8'd27, 8'd29, 7'd4,  7'd27)) seg = 3'd1;
    else if (inBox(x, y, 8'd27, 8'd29, 7'd29, 7'd47)) seg = 3'd2;
    else if (inBox(x, y, 8'd9,  8'd29, 7'd45, 7'd47)) seg = 3'd3;
    else if (inBox(x, y, 8'd9,  8'd11, 7'd29, 7'd47)) seg = 3'd4;
    else if (inBox(x, y, 8'd9,  8'd11, 7'd4,  7'd27)) seg = 3'd5;
    else if (inBox(x, y, 8'd9,  8'd29, 7'd26, 7'd28)) seg = 3'd6;
    return seg;
  endfunction

  assign w_hitSeg     = hitSeg(i_x_cursor, i_y_cursor);
  assign w_press      = i_left_click & ~r_leftQ;
  assign w_release    = ~i_left_click & r_leftQ;
  assign w_rclick     = i_right_click & ~r_rightQ;
  assign w_onSel      = (r_selSeg != NO_SEG) && (w_hitSeg == r_selSeg);
  assign w_toggleMask = 7'd1 << r_selSeg;

  // A toggle needs press and release on the same segment; clear overrides the
  // segment vector last, and suppresses the strobe since nothing visibly changed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_holdCnt      <= '0;
      r_selSeg       <= NO_SEG;
      r_hoverSeg     <= NO_SEG;
      r_mouseClick   <= '0;
      r_toggleStrobe <= 1'b0;
      r_leftQ        <= 1'b0;
      r_rightQ       <= 1'b0;
    end else begin
      r_leftQ        <= i_left_click;
      r_rightQ       <= i_right_click;
      r_hoverSeg     <= w_hitSeg;
      r_toggleStrobe <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_selSeg <= w_hitSeg;
            r_state  <= S_PRESSED;
          end else if (w_rclick) begin
            r_mouseClick <= '0;
          end
        end

        S_PRESSED: begin
          if (w_release) begin
            if (w_onSel) begin
              r_mouseClick   <= r_mouseClick ^ w_toggleMask;
              r_toggleStrobe <= ~i_clear;
              if (HOLDOFF_CYCLES == 0) begin
                r_state <= S_IDLE;
              end else begin
                r_state   <= S_HOLDOFF;
                r_holdCnt <= CNT_LOAD;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_HOLDOFF: begin
          if (r_holdCnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_holdCnt <= r_holdCnt - CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase

      if (i_clear) begin
        r_mouseClick <= '0;
      end
    end
  end

  assign o_mouse_click   = r_mouseClick;
  assign o_hover_seg     = r_hoverSeg;
  assign o_toggle_strobe = r_toggleStrobe;
  assign o_busy          = (r_state != S_IDLE);

endmodule
